// File: rtl/id_ex_alu_ctrl.sv
// ID/EX ALU-control decode register: 1-cycle latency, fully registered outputs; stall holds, flush squashes.
// Define ALU_ILLEGAL_TRAP_EN to trap unsupported funct3/funct7 as illegal and count them.
module id_ex_alu_ctrl #(
  parameter int XLEN   = 32,
  parameter int ICNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [3:0]        ex_alu_sel,
  output logic [XLEN-1:0]   ex_op_a,
  output logic [XLEN-1:0]   ex_op_b,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_illegal,
  output logic [ICNT_W-1:0] illegal_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_b5;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;

  logic [3:0]      d_sel;
  logic [XLEN-1:0] d_op_b;
  logic [XLEN-1:0] d_imm;
  logic            d_rw;
  logic            d_mr;
  logic            d_mw;
  logic            d_br;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic            d_ill;
  logic            f3_supported;
`endif

  // rs1 address bits are resolved by the register file, not here
  logic unused_rs1_addr;
  assign unused_rs1_addr = ^id_instr[19:15];

  assign opcode    = id_instr[6:0];
  assign funct3    = id_instr[14:12];
  assign funct7_b5 = id_instr[30];

  assign imm_i = {{(XLEN-12){id_instr[31]}}, id_instr[31:20]};
  assign imm_s = {{(XLEN-12){id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
  assign imm_b = {{(XLEN-13){id_instr[31]}}, id_instr[31], id_instr[7],
                  id_instr[30:25], id_instr[11:8], 1'b0};

`ifdef ALU_ILLEGAL_TRAP_EN
  assign f3_supported = (funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111);
`endif

  always_comb begin
    d_sel  = 4'b0000;
    d_op_b = id_rs2_data;
    d_imm  = '0;
    d_rw   = 1'b0;
    d_mr   = 1'b0;
    d_mw   = 1'b0;
    d_br   = 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
    d_ill  = 1'b0;
`endif
    case (opcode)
      OP_R: begin
        d_sel = {funct7_b5, funct3};
        d_rw  = 1'b1;
`ifdef ALU_ILLEGAL_TRAP_EN
        d_ill = !f3_supported || (funct7_b5 && funct3 != 3'b000);
`endif
      end
      OP_I: begin
        // instr[30] is an immediate bit here, so only funct3 is screened
        d_sel  = {1'b0, funct3};
        d_op_b = imm_i;
        d_imm  = imm_i;
        d_rw   = 1'b1;
`ifdef ALU_ILLEGAL_TRAP_EN
        d_ill  = !f3_supported;
`endif
      end
      OP_LOAD: begin
        d_op_b = imm_i;
        d_imm  = imm_i;
        d_rw   = 1'b1;
        d_mr   = 1'b1;
      end
      OP_STORE: begin
        d_op_b = imm_s;
        d_imm  = imm_s;
        d_mw   = 1'b1;
      end
      OP_BRANCH: begin
        d_sel = 4'b1000;
        d_imm = imm_b;
        d_br  = 1'b1;
`ifdef ALU_ILLEGAL_TRAP_EN
        d_ill = (funct3 != 3'b000);
`endif
      end
      default: begin
`ifdef ALU_ILLEGAL_TRAP_EN
        d_ill = 1'b1;
`endif
      end
    endcase
`ifdef ALU_ILLEGAL_TRAP_EN
    if (d_ill) begin
      d_sel = 4'b0000;
      d_rw  = 1'b0;
      d_mr  = 1'b0;
      d_mw  = 1'b0;
      d_br  = 1'b0;
    end
`endif
  end

  // flush only clears valid/strobes; the datapath is left holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_alu_sel   <= 4'b0000;
      ex_op_a      <= '0;
      ex_op_b      <= '0;
      ex_rs2_data  <= '0;
      ex_imm       <= '0;
      ex_rd_addr   <= 5'd0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
    end else if (flush) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_branch    <= 1'b0;
    end else if (!stall) begin
      ex_valid     <= id_valid;
      ex_alu_sel   <= d_sel;
      ex_op_a      <= id_rs1_data;
      ex_op_b      <= d_op_b;
      ex_rs2_data  <= id_rs2_data;
      ex_imm       <= d_imm;
      ex_rd_addr   <= id_instr[11:7];
      ex_reg_write <= id_valid & d_rw;
      ex_mem_read  <= id_valid & d_mr;
      ex_mem_write <= id_valid & d_mw;
      ex_branch    <= id_valid & d_br;
    end
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_illegal    <= 1'b0;
      illegal_count <= '0;
    end else if (flush) begin
      ex_illegal <= 1'b0;
    end else if (!stall) begin
      ex_illegal <= id_valid & d_ill;
      if (id_valid && d_ill && !(&illegal_count)) begin
        illegal_count <= illegal_count + 1'b1;
      end
    end
  end
`else
  assign ex_illegal    = 1'b0;
  assign illegal_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Randomized bench for id_ex_alu_ctrl with a cycle-level reference model and directed anchor checks.
module tb_id_ex_alu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0;
  logic [31:0] id_rs1_data = '0;
  logic [31:0] id_rs2_data = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic [3:0]  ex_alu_sel;
  logic [31:0] ex_op_a, ex_op_b, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
  logic [7:0]  illegal_count;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef ALU_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  id_ex_alu_ctrl #(.XLEN(32), .ICNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_sel(ex_alu_sel), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rd_addr(ex_rd_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic        rw, mr, mw, br, ill;
  } dec_t;

  // Reference decode written from the instruction-set rules
  function automatic dec_t model_dec(input logic [31:0] ins, input logic [31:0] rs2);
    dec_t d;
    int f3;
    bit alt, f3_ok;
    logic [31:0] i_imm, s_imm, b_imm;
    f3    = int'(ins[14:12]);
    alt   = ins[30];
    f3_ok = (f3 == 0) || (f3 == 6) || (f3 == 7);
    i_imm = 32'($signed(ins) >>> 20);
    s_imm = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
    b_imm = (32'($signed(ins) >>> 31) << 12) | (32'(ins[7]) << 11)
          | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    d = '0;
    d.op_b = rs2;
    case (ins[6:0])
      7'h33: begin d.sel = 4'(f3 + (alt ? 8 : 0)); d.rw = 1; d.ill = TRAP && (!f3_ok || (alt && f3 != 0)); end
      7'h13: begin d.sel = 4'(f3); d.op_b = i_imm; d.imm = i_imm; d.rw = 1; d.ill = TRAP && !f3_ok; end
      7'h03: begin d.op_b = i_imm; d.imm = i_imm; d.rw = 1; d.mr = 1; end
      7'h23: begin d.op_b = s_imm; d.imm = s_imm; d.mw = 1; end
      7'h63: begin d.sel = 4'd8; d.imm = b_imm; d.br = 1; d.ill = TRAP && (f3 != 0); end
      default: d.ill = TRAP;
    endcase
    if (d.ill) begin
      d.sel = 0; d.rw = 0; d.mr = 0; d.mw = 0; d.br = 0;
    end
    return d;
  endfunction

  logic        m_valid = 1'b0;
  dec_t        m_d = '0;
  logic [31:0] m_a = '0, m_rs2 = '0;
  logic [4:0]  m_rd = '0;
  int          m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_d = '0; m_a = 0; m_rs2 = 0; m_rd = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0; m_d.rw = 0; m_d.mr = 0; m_d.mw = 0; m_d.br = 0; m_d.ill = 0;
    end else if (!stall) begin
      dec_t d;
      d = model_dec(id_instr, id_rs2_data);
      m_valid = id_valid;
      m_a     = id_rs1_data;
      m_rs2   = id_rs2_data;
      m_rd    = id_instr[11:7];
      m_d     = d;
      if (!id_valid) begin
        m_d.rw = 0; m_d.mr = 0; m_d.mw = 0; m_d.br = 0; m_d.ill = 0;
      end else if (d.ill && m_cnt < 255) begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", 32'(ex_valid), 32'(m_valid));
    chk("strobes", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch},
        {28'd0, m_d.rw, m_d.mr, m_d.mw, m_d.br});
    chk("illegal", 32'(ex_illegal), 32'(m_d.ill));
    chk("count", 32'(illegal_count), 32'(m_cnt));
    if (m_valid) begin
      chk("alu_sel", 32'(ex_alu_sel), 32'(m_d.sel));
      chk("op_a", ex_op_a, m_a);
      chk("op_b", ex_op_b, m_d.op_b);
      chk("rs2_data", ex_rs2_data, m_rs2);
      chk("imm", ex_imm, m_d.imm);
      chk("rd", 32'(ex_rd_addr), 32'(m_rd));
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] r1, r2,
                      input logic st, input logic fl);
    id_valid = v; id_instr = ins; id_rs1_data = r1; id_rs2_data = r2; stall = st; flush = fl;
    @(posedge clk);
    #2;
  endtask

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_SUB = 32'h402081B3;
  localparam logic [31:0] I_ORI = 32'h0F00E293;
  localparam logic [31:0] I_SW  = 32'h0020A423;
  localparam logic [31:0] I_XOR = 32'h0020C1B3;
  localparam logic [31:0] I_LW  = 32'h0040A183;

  initial begin
    logic [6:0] opcs [5];
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_op_a", ex_op_a, 32'd0);
    chk("rst_count", 32'(illegal_count), 32'd0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;

    step(0, I_ADD, 5, 7, 0, 0);
    chk("bubble_valid", 32'(ex_valid), 32'd0);

    step(1, I_ADD, 5, 7, 0, 0);
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_sel", 32'(ex_alu_sel), 32'h0);
    chk("add_op_a", ex_op_a, 32'd5);
    chk("add_op_b", ex_op_b, 32'd7);
    chk("add_rd", 32'(ex_rd_addr), 32'd3);
    chk("add_rw", 32'(ex_reg_write), 32'd1);

    step(1, I_SUB, 9, 4, 0, 0);
    chk("sub_sel", 32'(ex_alu_sel), 32'h8);
    chk("sub_op_b", ex_op_b, 32'd4);
    step(1, I_ORI, 9, 4, 0, 0);
    chk("ori_sel", 32'(ex_alu_sel), 32'h6);
    chk("ori_op_b", ex_op_b, 32'h0000_00F0);
    chk("ori_rd", 32'(ex_rd_addr), 32'd5);

    step(1, I_SW, 32'h100, 32'hDEADBEEF, 0, 0);
    chk("sw_sel", 32'(ex_alu_sel), 32'h0);
    chk("sw_op_b", ex_op_b, 32'd8);
    chk("sw_data", ex_rs2_data, 32'hDEADBEEF);
    chk("sw_mw", 32'(ex_mem_write), 32'd1);
    chk("sw_rw", 32'(ex_reg_write), 32'd0);

    step(1, I_XOR, 1, 2, 0, 0);
`ifdef ALU_ILLEGAL_TRAP_EN
    chk("xor_valid", 32'(ex_valid), 32'd1);
    chk("xor_illegal", 32'(ex_illegal), 32'd1);
    chk("xor_rw", 32'(ex_reg_write), 32'd0);
    chk("xor_sel", 32'(ex_alu_sel), 32'h0);
    chk("xor_count1", 32'(illegal_count), 32'd1);
    for (int i = 0; i < 299; i++) step(1, I_XOR, 1, 2, 0, 0);
    chk("xor_count_sat", 32'(illegal_count), 32'd255);
`else
    chk("xor_sel", 32'(ex_alu_sel), 32'h4);
    chk("xor_rw", 32'(ex_reg_write), 32'd1);
    chk("xor_count0", 32'(illegal_count), 32'd0);
`endif

    step(1, I_ADD, 5, 7, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, I_SUB, 11, 12, 1, 0);
      chk("stall_sel", 32'(ex_alu_sel), 32'h0);
      chk("stall_op_b", ex_op_b, 32'd7);
      chk("stall_valid", 32'(ex_valid), 32'd1);
    end
    step(1, I_SUB, 11, 12, 1, 1);
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_rw", 32'(ex_reg_write), 32'd0);

    step(1, I_LW, 32'h40, 0, 0, 0);
    chk("lw_mr", 32'(ex_mem_read), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ex_valid), 32'd0);
    chk("arst_mr", 32'(ex_mem_read), 32'd0);
    chk("arst_op_a", ex_op_a, 32'd0);
    chk("arst_count", 32'(illegal_count), 32'd0);
    id_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    step(0, I_LW, 32'h40, 0, 0, 0);
    chk("post_rst_bubble", 32'(ex_valid), 32'd0);
    step(1, I_LW, 32'h40, 0, 0, 0);
    chk("post_rst_valid", 32'(ex_valid), 32'd1);
    chk("post_rst_op_b", ex_op_b, 32'd4);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      logic [6:0]  opc;
      int k;
      r = $urandom();
      k = $urandom_range(0, 5);
      opc = (k == 5) ? 7'($urandom()) : opcs[k];
      if (opc == 7'h33 && $urandom_range(0, 3) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
      step($urandom_range(0, 9) < 8, {r[31:7], opc}, $urandom(), $urandom(),
           $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_ctrl.md
# id_ex_alu_ctrl

Decode-side producer of the ALU control interface. Takes a fetched instruction plus register-file read data in the ID stage and decodes opcode/funct3/funct7 into the 4-bit `alu_sel` encoding the execute-stage ALU consumes. It generates the immediate, selects operand B and registers everything into the ID/EX pipeline boundary, with stall and flush handling. Sits between the register file and the ALU in the pipelined RISC-V core.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `ICNT_W`, 8, width of the illegal-instruction counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `id_valid`  in  1  instruction in ID is valid.
- `id_instr`  in  32  raw instruction.
- `id_rs1_data`  in  XLEN  register-file read port 1.
- `id_rs2_data`  in  XLEN  register-file read port 2.
- `stall`  in  1  hold ID/EX contents.
- `flush`  in  1  squash the instruction entering EX.
- `ex_valid`  out  1  EX-stage instruction valid.
- `ex_alu_sel`  out  4  ALU control: bit3 = subtract, [2:0] = 000 sum, 110 OR, 111 AND.
- `ex_op_a`  out  XLEN  ALU operand A.
- `ex_op_b`  out  XLEN  ALU operand B.
- `ex_rs2_data`  out  XLEN  store data.
- `ex_imm`  out  XLEN  sign-extended immediate.
- `ex_rd_addr`  out  5  destination register.
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`  out  1 each  control strobes.
- `ex_illegal`  out  1  instruction not supported by the ALU.
- `illegal_count`  out  ICNT_W  saturating count of accepted illegal instructions.

## Operation
- Decode (combinational, ID side):
  - R-type (0110011): `alu_sel = {funct7[5], funct3}`, op_b = rs2, reg_write.
  - I-ALU (0010011): `alu_sel = {0, funct3}`, op_b = I-imm, reg_write.
  - Load (0000011): sel 0000, op_b = I-imm, reg_write, mem_read.
  - Store (0100011): sel 0000, op_b = S-imm, mem_write.
  - Branch (1100011, funct3 000 only): sel 1000, op_b = rs2, branch, `ex_imm` = B-imm.
- Operand A is always `id_rs1_data`.
- Immediates are sign-extended from instr[31].
- Unknown opcode: all strobes 0 and illegal.
- funct3 legality is per the Configuration section.
- An illegal instruction enters EX with `ex_valid=1`, `ex_illegal=1`, all write/read/branch strobes 0, and `alu_sel` 0000.
- Accept condition: `id_valid & ~stall & ~flush`.
  - On accept of an illegal instruction, `illegal_count` increments.
  - It saturates at all-ones with no wrap.

## Timing
- Reset (async, immediate): `ex_valid`, all strobes, `ex_illegal`, `ex_alu_sel`, operands, `ex_imm`, `ex_rd_addr` and `illegal_count` all 0.
- Latency: ID inputs at edge N appear on the `ex_*` outputs after edge N. Outputs are fully registered, with no combinational path from inputs.
- Priority per edge: flush > stall > load.
- `flush=1`: `ex_valid` and all strobes go to 0 next cycle, even if `stall=1`. Datapath registers may hold. No count increment.
- `stall=1` (no flush): every `ex_*` output and `illegal_count` hold.
- `id_valid=0` (no stall/flush): a bubble is loaded, i.e. `ex_valid=0` with strobes 0.
- Reset asserted mid-stall or mid-flush returns everything to the reset values. The first valid instruction after deassertion appears one cycle after it is loaded.

## Configuration
- `ALU_ILLEGAL_TRAP_EN` defined:
  - For R/I-ALU, only funct3 ∈ {000, 110, 111} is legal.
  - funct7[5]=1 is legal only for R-type with funct3 000.
  - Branch funct3 ≠ 000 is illegal.
  - Illegal handling and `illegal_count` are as above.
- Macro undefined:
  - No funct3/funct7 checking. `alu_sel` is passed through as decoded, with strobes set per opcode.
  - Only an unknown opcode produces bubble strobes.
  - `ex_illegal` and `illegal_count` are tied to 0.

## Test plan
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 → next cycle `ex_valid=1`, sel 0000, op_a=5, op_b=7, rd=3, reg_write=1.
- sub (0x402081B3) then ori x5,x1,0x0F0 (0x0F00E293), back to back → sel 1000, op_b=rs2; then sel 0110, op_b=0x000000F0, rd=5.
- sw x2,8(x1) (0x0020A423), rs2=0xDEADBEEF → sel 0000, op_b=8, `ex_rs2_data`=0xDEADBEEF, mem_write=1, reg_write=0.
- xor (0x0020C1B3) with macro defined → `ex_valid=1`, `ex_illegal=1`, strobes 0, count 0→1. Repeat 300 accepts with ICNT_W=8 → count holds at 255. Macro undefined → sel 0100, reg_write=1, count stays 0.
- add, then `stall=1` for 3 cycles with a new instruction at the input → outputs hold the add. Then `flush=1` together with stall → `ex_valid=0` next cycle.
- Pulse `rst_n` low mid-cycle during a valid load → all outputs 0 immediately. After release, a bubble until the next accepted instruction.
